// File: rtl/ex_scoreboard_pkg.sv
// Shared pipeline types for the issue scoreboard: operand-source selects and
// the drain FSM state encoding.
package ex_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EXWB = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/ex_scoreboard_src_hazard_check.sv
// One source operand: picks the youngest in-flight producer and flags a stall
// when the register is still pending and no bypass covers it.
module src_hazard_check
  import ex_scoreboard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_idx,
  input  logic                 src_used,
  input  logic                 src_pending,
  input  logic                 ex_fwd_valid,
  input  logic [REG_IDX_W-1:0] ex_fwd_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic [1:0]           fwd_sel,
  output logic                 hazard
);

  fwd_sel_t sel;
  logic     src_live;

  assign src_live = src_used && (src_idx != '0);

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (src_live) begin
      // EX_WB holds the younger result, so it wins over WB.
      if (ex_fwd_valid && ex_fwd_rd == src_idx) begin
        sel = FWD_EXWB;
      end else if (wb_valid && wb_rd == src_idx) begin
        sel = FWD_WB;
      end
    end
  end

  assign fwd_sel = sel;
  assign hazard  = src_live && src_pending && (sel == FWD_RF);

endmodule

// File: rtl/ex_scoreboard.sv
// Register scoreboard in front of ID_EX: tracks outstanding writers, selects
// operand bypass sources, stalls on RAW/WAW hazards and drains for fence/ecall.
module ex_scoreboard
  import ex_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic                 issue_rs1_used,
  input  logic                 issue_rs2_used,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_rd_wr_en,
  output logic                 issue_ready,
  output logic [1:0]           issue_fwd_a,
  output logic [1:0]           issue_fwd_b,
  input  logic                 ex_fwd_valid,
  input  logic [REG_IDX_W-1:0] ex_fwd_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 kill_valid,
  input  logic [REG_IDX_W-1:0] kill_rd,
  input  logic                 flush,
  input  logic                 drain_req,
  output logic                 drain_done,
  output logic [CNT_W-1:0]     pending_cnt,
  output logic                 sb_busy
);

  logic [NREGS-1:0] pending_q, pending_d, set_vec, clr_vec;
  logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;
  sb_state_t        state_q, state_d;

  logic haz_a, haz_b, waw, rd_covered, fire;

  src_hazard_check u_rs1 (
    .src_idx      (issue_rs1),
    .src_used     (issue_rs1_used),
    .src_pending  (pending_q[issue_rs1]),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_fwd_rd    (ex_fwd_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .fwd_sel      (issue_fwd_a),
    .hazard       (haz_a)
  );

  src_hazard_check u_rs2 (
    .src_idx      (issue_rs2),
    .src_used     (issue_rs2_used),
    .src_pending  (pending_q[issue_rs2]),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_fwd_rd    (ex_fwd_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .fwd_sel      (issue_fwd_b),
    .hazard       (haz_b)
  );

  // A new write to a still-pending rd is safe once its older writer is
  // already leaving through EX_WB or WB this cycle.
  assign rd_covered = (ex_fwd_valid && ex_fwd_rd == issue_rd) ||
                      (wb_valid && wb_rd == issue_rd);
  assign waw        = issue_rd_wr_en && (issue_rd != '0) &&
                      pending_q[issue_rd] && !rd_covered;

  assign issue_ready = (state_q == SB_RUN) && !haz_a && !haz_b && !waw;
  assign fire        = issue_valid && issue_ready && !flush;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (wb_valid)   clr_vec[wb_rd]   = 1'b1;
    if (kill_valid) clr_vec[kill_rd] = 1'b1;
    if (fire && issue_rd_wr_en) set_vec[issue_rd] = 1'b1;
    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;

    pending_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_cnt_d = pending_cnt_d + CNT_W'(pending_d[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_RUN:   if (drain_req) state_d = SB_DRAIN;
      SB_DRAIN: if (pending_d == '0) state_d = SB_DONE;
      SB_DONE:  state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the pending vector is a flop array rather than a RAM, so it takes
  // the asynchronous reset; a drain aborted by reset must not leave stale bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      pending_cnt_q <= '0;
      state_q       <= SB_RUN;
    end else begin
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
      state_q       <= state_d;
    end
  end

  assign pending_cnt = pending_cnt_q;
  assign drain_done  = (state_q == SB_DONE);
  assign sb_busy     = (state_q != SB_RUN);

endmodule

// File: doc/ex_scoreboard.md
EX_SCOREBOARD -- requirements
Module: ex_scoreboard

Interface
REQ-001 Parameters SHALL be: NREGS, 32, architectural register count; CNT_W, 6, width of outstanding-writer count.
REQ-002 Clock and reset SHALL be one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock) and reset_n (in, 1, asynchronous active-low reset).
REQ-003 Issue inputs SHALL be: issue_valid in 1, decoded instr offered; issue_rs1/issue_rs2 in 5 each, source indices; issue_rs1_used/issue_rs2_used in 1 each; issue_rd in 5; issue_rd_wr_en in 1.
REQ-004 issue_ready out 1 SHALL mean the offered instr may enter ID_EX this cycle.
REQ-005 issue_fwd_a/issue_fwd_b out 2 each SHALL be fwd_sel_t operand-source selects for alu_reg_input_a/b.
REQ-006 Forward-source inputs SHALL be: ex_fwd_valid in 1, EX_WB holds ready ALU result; ex_fwd_rd in 5.
REQ-007 Writeback and kill inputs SHALL be: wb_valid in 1; wb_rd in 5; kill_valid in 1, squash of an in-flight writer; kill_rd in 5; flush in 1, squash the offered instr.
REQ-008 Drain ports SHALL be: drain_req in 1, fence/ecall pulse; drain_done out 1, one-cycle pulse.
REQ-009 Status ports SHALL be: pending_cnt out CNT_W, outstanding writers; sb_busy out 1, state != SB_RUN.

Function
REQ-010 fire SHALL equal issue_valid & issue_ready & ~flush.
REQ-011 On fire with issue_rd_wr_en=1 and issue_rd!=0, pending[issue_rd] SHALL be set at the next edge.
REQ-012 wb_valid SHALL clear pending[wb_rd] at the next edge; kill_valid SHALL clear pending[kill_rd].
REQ-013 A same-cycle set and clear of one index SHALL leave the bit set.
REQ-014 pending[0] SHALL always be 0, and writes to x0 SHALL be ignored.
REQ-015 Operand select per used source s!=0 SHALL be: ex_fwd_valid & ex_fwd_rd==s -> FWD_EXWB; else wb_valid & wb_rd==s -> FWD_WB; else FWD_RF.
REQ-016 EX_WB SHALL take priority over WB because it is the younger source.
REQ-017 An unused source or s==0 SHALL always select FWD_RF.
REQ-018 A source hazard SHALL be a used source s!=0 with pending[s]=1 and select FWD_RF.
REQ-019 A WAW hazard SHALL be issue_rd_wr_en with issue_rd!=0, pending[issue_rd]=1, and that rd not covered by ex_fwd/wb this cycle.
REQ-020 issue_ready SHALL equal (state==SB_RUN) & ~hazard on either source & ~WAW, and SHALL be combinational.
REQ-021 Selects SHALL be combinational and valid whenever issue_valid=1.
REQ-022 pending_cnt SHALL be registered and equal popcount(pending) after each edge, range 0..31, never wrapping.
REQ-023 FSM states SHALL be SB_RUN, SB_DRAIN, SB_DONE.
REQ-024 In SB_RUN, drain_req SHALL go to SB_DRAIN; fire in that same cycle SHALL still complete.
REQ-025 In SB_DRAIN, issue_ready SHALL be 0, and when next-state pending==0 the FSM SHALL go to SB_DONE.
REQ-026 SB_DONE SHALL assert drain_done for exactly 1 cycle, then go to SB_RUN.
REQ-027 drain_req SHALL be ignored in SB_DRAIN and SB_DONE.
REQ-028 drain_req with pending already 0 SHALL reach SB_DONE one cycle later.
REQ-029 flush SHALL suppress that cycle's fire only, with no effect on FSM or pending.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately set pending to all 0, state to SB_RUN, drain_done to 0, and pending_cnt to 0, including mid-drain.
REQ-031 Combinational outputs SHALL follow from the reset state: issue_ready=1 and selects FWD_RF.

Structure
REQ-032 fwd_sel_t {FWD_RF=0, FWD_EXWB=1, FWD_WB=2} and sb_state_t SHALL live in the shared pipeline package next to ID_EX/EX_WB.
REQ-033 The per-source compare/select SHALL be one sub-module src_hazard_check, instanced twice (rs1, rs2).
REQ-034 alu_stage SHALL consume issue_fwd_a/b via its existing operand muxes without change to its own logic.

Verification
REQ-035 Bench SHALL cover: issue addi x5 (rd=5), then next cycle add x6,x5,x5 with ex_fwd_valid=1, ex_fwd_rd=5 -> issue_ready=1, both fwd=FWD_EXWB, pending_cnt=2.
REQ-036 Bench SHALL cover: pending[7]=1, offer rs1=7 with no fwd/wb match -> issue_ready=0; assert wb_valid, wb_rd=7 -> same cycle issue_ready=1, fwd_a=FWD_WB.
REQ-037 Bench SHALL cover: same-cycle fire rd=3 and wb_rd=3 -> pending[3]=1, pending_cnt unchanged.
REQ-038 Bench SHALL cover: issue rd=0 and rs1=0 -> pending_cnt stays 0, fwd_a=FWD_RF even with ex_fwd_rd=0, ex_fwd_valid=1.
REQ-039 Bench SHALL cover: pending={x2,x9}, drain_req -> sb_busy=1 and issue_ready=0; wb x2, then kill x9 -> drain_done pulses 1 cycle after the edge where pending_cnt becomes 0, then SB_RUN.
REQ-040 Bench SHALL cover: reset_n low mid-SB_DRAIN with pending_cnt=4 -> pending_cnt=0, drain_done=0, issue_ready=1 without a clock edge.
